muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative multi-cycle multiply/divide engine beside the single-cycle ALU in the MIPS datapath.
//  Executes MULT/MULTU/DIV/DIVU and owns the HI/LO registers read by MFHI/MFLO and written by MTHI/MTLO.
//  Control issues start with operands. It stalls the pipeline on busy and resumes on the done pulse.
// PARAMETERS
//  WIDTH  32  operand/HI/LO width in bits; iteration count equals WIDTH
// PORTS
//  clk      in   1      rising-edge clock
//  reset    in   1      synchronous, active-high reset
//  start    in   1      launch request; accepted only in IDLE
//  op       in   2      00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
//  in1      in   WIDTH  multiplicand / dividend (rs)
//  in2      in   WIDTH  multiplier / divisor (rt)
//  hi_we    in   1      MTHI write strobe
//  lo_we    in   1      MTLO write strobe
//  wdata    in   WIDTH  MTHI/MTLO data
//  busy     out  1      operation in progress
//  done     out  1      one-cycle pulse: HI/LO hold the new result
//  hi       out  WIDTH  HI register (product[63:32] / remainder)
//  lo       out  WIDTH  LO register (product[31:0] / quotient)
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0; overrides all other inputs at that edge.
//  FSM states:
//   IDLE -> CALC: on start at edge E0. Latch op and |in1|, |in2|; magnitude is used only for signed ops.
//                 Latch the result sign: product sign = in1[31]^in2[31]; remainder sign = in1[31].
//   CALC: one iteration per edge, E1..E32 (counter 0..WIDTH-1).
//         Multiply is shift-add. Divide is restoring, one quotient bit per edge.
//   CALC -> FIN: after the iteration at counter = WIDTH-1.
//   FIN -> IDLE: at E33, apply two's-complement sign fix-up and write hi/lo.
//  Latency: busy=1 from the E0 edge through the E33 edge. done=1 for exactly the cycle after E33.
//  Back-to-back: start may be asserted in the same cycle that done is high. It is accepted (state=IDLE).
//  start while busy: ignored; the in-flight operation is unaffected.
//  hi_we/lo_we: honoured only when busy=0 and take effect at the next edge.
//   - While busy, both strobes are ignored.
//   - hi_we with start in the same IDLE cycle: the write lands, then the result overwrites it at E33.
//   - hi_we and lo_we together: both registers take wdata.
//  Width rules:
//   - Product is 2*WIDTH bits: hi = product[2W-1:W], lo = product[W-1:0].
//   - Signed quotient truncates toward zero. Remainder takes the sign of the dividend.
//  Divide by zero (DIV or DIVU): lo = all ones, hi = in1 unmodified; same 33-cycle latency.
//  Signed overflow, 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
//  Multiply sign case: MULT of 0x80000000 x 0x80000000 gives hi = 0x40000000, lo = 0.
//  Reset mid-operation: returns to IDLE at that edge. No done pulse; hi/lo are cleared.
//  Outputs busy, done, hi and lo are all registered; no combinational input-to-output path.
// TESTING
//  1. MULT in1=0xFFFFFFFD (-3), in2=5 -> done after 33 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//  2. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//     MULT of the same operands -> hi=0, lo=1.
//  3. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIVU 100/7 -> lo=14, hi=2.
//     DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//  4. DIVU 100/0 -> lo=0xFFFFFFFF, hi=100, done at cycle 33.
//  5. Start DIVU 50/5. At cycle 10 pulse start with new operands, plus hi_we with wdata=0xDEAD.
//     Required: both ignored; result lo=10, hi=0. Then MTLO 0x1234 in IDLE -> lo=0x1234 next cycle.
//  6. Assert reset at cycle 15 of a MULT -> next cycle busy=0, hi=lo=0; no done pulse.
//     A new start two cycles later completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine owning the HI/LO registers.
// Shift-add multiply, restoring divide; one iteration per clock over WIDTH cycles.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]   counter;
  logic               div_r;
  logic               sign_q;
  logic               sign_r;
  logic               div_zero;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] acc;

  logic               signed_op;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_CALC;
      S_CALC:  if (counter == LAST) state_next = S_FIN;
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Operands are reduced to magnitudes at launch; signs are reapplied in FIN.
  always_comb begin
    signed_op = ~op[0];
    mag1 = (signed_op && in1[WIDTH-1]) ? -in1 : in1;
    mag2 = (signed_op && in2[WIDTH-1]) ? -in2 : in2;
  end

  // acc = {high half, low half}: product accumulator / {remainder, dividend->quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb};
    div_ok    = ~div_diff[WIDTH+1];
    div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 acc[WIDTH-2:0], div_ok};
  end

  always_comb begin
    prod_fix = sign_q ? -acc : acc;
    quo_fix  = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (div_r) begin
      res_hi = rem_fix;
      res_lo = div_zero ? '1 : quo_fix;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_r    <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      opb      <= '0;
      acc      <= '0;
    end else begin
      busy <= (state_next != S_IDLE);
      done <= (state == S_FIN);
      case (state)
        S_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            div_r    <= op[1];
            sign_q   <= signed_op & (in1[WIDTH-1] ^ in2[WIDTH-1]);
            sign_r   <= signed_op & in1[WIDTH-1];
            div_zero <= (in2 == '0);
            opb      <= mag2;
            acc      <= {{WIDTH{1'b0}}, mag1};
            counter  <= '0;
          end
        end
        S_CALC: begin
          acc     <= div_r ? div_next : mul_next;
          counter <= counter + CNT_W'(1);
        end
        S_FIN: begin
          hi <= res_hi;
          lo <= res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule
